// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, majority voting on
// ticks 8/9/10 of each bit, and a 4-entry first-word-fall-through FIFO.
//
// State table
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a falling edge on rxs
//   ST_START | validating the start bit (majority at tick 10 must be 0)
//   ST_DATA  | shifting in 8 data bits, LSB first
//   ST_STOP  | deciding the stop bit at tick 10, then push or framing error
//   ST_BREAK | stop bit was 0; waiting for the line to return high
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   rxd        asynchronous serial input, idle high
//   rx_en      receiver enable; low forces the FSM to idle
//   pop        removes the FIFO head (ignored when empty)
//   err_clr    one-cycle pulse clearing frame_err and overrun
//   rx_data    FIFO head byte
//   rx_valid   FIFO not empty
//   rx_count   FIFO occupancy 0..4
//   frame_err  sticky: stop bit sampled as 0
//   overrun    sticky: good byte arrived while FIFO full
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 651,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic       pop,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [2:0] rx_count,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             meta_q, meta_d;
    logic             rxs_q, rxs_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_idx_q, tick_idx_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             samp8_q, samp8_d;
    logic             samp9_q, samp9_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [4];
    logic [7:0]       mem_d [4];
    logic [1:0]       wptr_q, wptr_d;
    logic [1:0]       rptr_q, rptr_d;
    logic [2:0]       count_q, count_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic tick, at10, at16, maj;
    logic push, fe_set, do_push, do_pop, full, ov_set;

    always_comb begin
        meta_d     = rxd;
        rxs_d      = meta_q;
        rxs_prev_d = rxs_q;
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        samp8_d    = samp8_q;
        samp9_d    = samp9_q;
        shift_d    = shift_q;
        push       = 1'b0;
        fe_set     = 1'b0;

        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        tick_idx_d = tick ? tick_idx_q + 4'd1 : tick_idx_q;

        // tick_idx_q holds the number of ticks already seen in this bit, so
        // the tick currently firing is number tick_idx_q + 1.
        at10 = tick && (tick_idx_q == 4'd9);
        at16 = tick && (tick_idx_q == 4'd15);
        if (tick && tick_idx_q == 4'd7) samp8_d = rxs_q;
        if (tick && tick_idx_q == 4'd8) samp9_d = rxs_q;
        // Third sample is taken live on tick 10 itself.
        maj = (samp8_q & samp9_q) | (samp8_q & rxs_q) | (samp9_q & rxs_q);

        case (state_q)
            ST_IDLE: begin
                if (rx_en && rxs_prev_q && !rxs_q) begin
                    div_d      = '0;
                    tick_idx_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (at10 && maj) begin
                    state_d = ST_IDLE;
                end else if (at16) begin
                    tick_idx_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at10) shift_d = {maj, shift_q[7:1]};
                if (at16) begin
                    tick_idx_d = '0;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                // Return to idle at mid-stop so the next start edge is not missed.
                if (at10) begin
                    if (maj) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling aborts the frame silently.
        if (!rx_en) begin
            state_d = ST_IDLE;
            push    = 1'b0;
            fe_set  = 1'b0;
        end

        full    = (count_q == 3'(FIFO_DEPTH));
        do_pop  = pop && (count_q != 3'd0);
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        do_push = push && (!full || do_pop);
        ov_set  = push && full && !do_pop;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = shift_q;
            wptr_d        = wptr_q + 2'd1;
        end
        if (do_pop) rptr_d = rptr_q + 2'd1;
        count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};

        frame_err_d = (frame_err_q & ~err_clr) | fe_set;
        overrun_d   = (overrun_q & ~err_clr) | ov_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            meta_q      <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            div_q       <= '0;
            tick_idx_q  <= '0;
            bit_idx_q   <= '0;
            samp8_q     <= 1'b1;
            samp9_q     <= 1'b1;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= meta_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            div_q       <= div_d;
            tick_idx_q  <= tick_idx_d;
            bit_idx_q   <= bit_idx_d;
            samp8_q     <= samp8_d;
            samp9_q     <= samp9_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = mem_q[rptr_q];
    assign rx_valid  = (count_q != 3'd0);
    assign rx_count  = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at BAUD_DIV = 4.
// A frame-level model (byte queue plus two flags, updated when each frame's
// stop decision is due) is compared against the DUT every cycle, and literal
// expectations pin key values of each scenario.
module tb_uart_rx_fifo;

    localparam int BIT_CYC = 64;
    // Drive edge -> 2 synchroniser cycles -> detect edge -> 154 ticks of 4.
    localparam int PUSH_LAT = 2 + 1 + 616;

    logic       clk = 1'b0;
    logic       reset, rxd, rx_en, pop, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err, overrun;

    uart_rx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rx_en(rx_en), .pop(pop),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        bit         bad;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] mq[$];
    bit         m_fe, m_ov;
    int         cyc = 0;
    int         tests = 0, fails = 0;
    bit         chk_en = 1'b0;
    int         k;
    logic [7:0] v;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: nothing but a byte queue and two sticky flags.
    initial begin : model
        ev_t e;
        bit  got, popped;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                ev_q.delete();
                m_fe = 1'b0;
                m_ov = 1'b0;
            end else begin
                popped = pop && (mq.size() > 0);
                got    = 1'b0;
                if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                    e   = ev_q.pop_front();
                    got = 1'b1;
                end
                if (err_clr) begin
                    m_fe = 1'b0;
                    m_ov = 1'b0;
                end
                if (popped) void'(mq.pop_front());
                if (got) begin
                    if (e.bad)                m_fe = 1'b1;
                    else if (mq.size() < 4)   mq.push_back(e.b);
                    else                      m_ov = 1'b1;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid", int'(rx_valid), int'(mq.size() > 0));
                check("count", int'(rx_count), mq.size());
                if (mq.size() > 0) check("data", int'(rx_data), int'(mq[0]));
                check("frame_err", int'(frame_err), int'(m_fe));
                check("overrun", int'(overrun), int'(m_ov));
            end
        end
    end

    // Called at a negedge; registers when the stop decision will land.
    task automatic tx_frame(input logic [7:0] b, input logic stop_bit, input int stop_bits);
        ev_t e;
        e.cyc = cyc + PUSH_LAT;
        e.b   = b;
        e.bad = !stop_bit;
        ev_q.push_back(e);
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT_CYC * stop_bits) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp_b);
        check(name, int'(rx_data), int'(exp_b));
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin : stim
        reset = 1'b1; rxd = 1'b1; rx_en = 1'b1; pop = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(rx_data), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_count", int'(rx_count), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (20) @(negedge clk);

        // 1: single byte, latency to rx_valid
        fork
            tx_frame(8'hA5, 1'b1, 1);
            begin
                k = 0;
                while (!rx_valid && k < 800) begin
                    @(negedge clk);
                    k++;
                end
                check("t1_latency", k, 619);
                check("t1_data", int'(rx_data), 8'hA5);
                check("t1_count", int'(rx_count), 1);
            end
        join
        pop_expect("t1_pop", 8'hA5);
        check("t1_count_after", int'(rx_count), 0);
        check("t1_valid_after", int'(rx_valid), 0);
        check("t1_flags", int'({frame_err, overrun}), 0);

        // 2: start glitch
        rxd = 1'b0;
        repeat (24) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("t2_glitch_count", int'(rx_count), 0);
        tx_frame(8'h3C, 1'b1, 1);
        check("t2_count", int'(rx_count), 1);
        pop_expect("t2_pop", 8'h3C);

        // 3: framing error with a long break
        tx_frame(8'h3C, 1'b0, 4);
        check("t3_frame_err", int'(frame_err), 1);
        check("t3_not_stored", int'(rx_count), 0);
        tx_frame(8'h11, 1'b1, 1);
        check("t3_count", int'(rx_count), 1);
        pop_expect("t3_pop", 8'h11);
        clear_errs();
        check("t3_cleared", int'(frame_err), 0);

        // 4: overrun across pointer wrap
        for (int i = 1; i <= 5; i++) tx_frame(8'(i), 1'b1, 1);
        check("t4_count", int'(rx_count), 4);
        check("t4_overrun", int'(overrun), 1);
        for (int i = 1; i <= 4; i++) pop_expect("t4_pop", 8'(i));
        check("t4_empty", int'(rx_count), 0);
        clear_errs();
        check("t4_cleared", int'(overrun), 0);

        // 5: full FIFO with pop on the push edge
        for (int i = 8'h61; i <= 8'h64; i++) tx_frame(8'(i), 1'b1, 1);
        check("t5_full", int'(rx_count), 4);
        fork
            tx_frame(8'h66, 1'b1, 1);
            begin
                repeat (PUSH_LAT - 1) @(negedge clk);
                pop = 1'b1;
                @(negedge clk);
                pop = 1'b0;
                check("t5_count", int'(rx_count), 4);
                check("t5_overrun", int'(overrun), 0);
            end
        join
        pop_expect("t5_pop0", 8'h62);
        pop_expect("t5_pop1", 8'h63);
        pop_expect("t5_pop2", 8'h64);
        pop_expect("t5_pop3", 8'h66);
        check("t5_empty", int'(rx_count), 0);

        // 6: reset during data bit 4
        tx_frame(8'h21, 1'b1, 1);
        tx_frame(8'h22, 1'b1, 1);
        check("t6_queued", int'(rx_count), 2);
        v = 8'h5A;
        rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = v[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = v[4];
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rxd = 1'b1;
        check("t6_rst_data", int'(rx_data), 0);
        check("t6_rst_valid", int'(rx_valid), 0);
        check("t6_rst_count", int'(rx_count), 0);
        check("t6_rst_flags", int'({frame_err, overrun}), 0);
        repeat (200) @(negedge clk);
        tx_frame(8'h5A, 1'b1, 1);
        check("t6_count", int'(rx_count), 1);
        pop_expect("t6_pop", 8'h5A);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with a 4-entry receive FIFO, placed directly upstream of the peripheral register bank's UART receive-data register. It recovers 8N1 frames from the `rxd` pin using 16x oversampling and majority voting, and flags framing errors and overruns as sticky bits. It also lets the CPU-side bus logic pop bytes at its own pace, so back-to-back characters are not lost between polls or interrupts.

## Interface
Parameters:
- `BAUD_DIV`, default 651: `clk` cycles per oversample tick (100 MHz / (9600 × 16)); legal range ≥ 2.
- `FIFO_DEPTH`, default 4: fixed at 4 and must not be overridden; `rx_count` is sized for it.

Ports:
- `clk`, input, 1: system clock, the single clock of the block.
- `reset`, input, 1: synchronous, active-high reset.
- `rxd`, input, 1: asynchronous serial input, idle high.
- `rx_en`, input, 1: receiver enable, driven from UART_CON[1].
- `pop`, input, 1: removes the FIFO head; honoured only while `rx_valid` = 1.
- `err_clr`, input, 1: one-cycle pulse that clears `frame_err` and `overrun`.
- `rx_data`, output, 8: FIFO head byte (first-word fall-through).
- `rx_valid`, output, 1: FIFO not empty.
- `rx_count`, output, 3: FIFO occupancy, 0 to 4.
- `frame_err`, output, 1: sticky; set when a stop bit is sampled as 0.
- `overrun`, output, 1: sticky; set when a good byte arrives while the FIFO is full.

## Operation
Input synchronisation:
- `rxd` passes through a 2-flop synchroniser that resets to 1, giving `rxs`.
- A registered copy `rxs_d` is kept for edge detection.

Oversample timing:
- A divider counts 0 to BAUD_DIV−1. `tick` pulses for one cycle when the divider equals BAUD_DIV−1.
- Divider and tick index are cleared when a start is detected.
- Tick indices within each bit count 1 to 16. Samples are taken on ticks 8, 9 and 10. The bit value is the majority of the three and is decided on tick 10.

State machine (IDLE, START, DATA, STOP, BREAK):
- **IDLE:** on `rx_en` = 1 and `rxs_d` = 1, `rxs` = 0 (falling edge), clear the divider and tick index, then go to START.
- **START:** at tick 10, a majority of 1 is a glitch and returns to IDLE with no side effects. Otherwise continue. At tick 16, go to DATA with bit index 0.
- **DATA:** 8 bits, LSB first, each decided into a shift register at tick 10. At tick 16 of bit 7, go to STOP.
- **STOP:** decided at tick 10.
  - If 1: push the byte and go to IDLE immediately. This leaves a half-bit of slack for the next start edge.
  - If 0: discard the byte, set `frame_err`, and go to BREAK.
- **BREAK:** wait for `rxs` = 1, then go to IDLE.
- `rx_en` = 0 in any state forces IDLE on the next edge. An in-flight frame is discarded with no flags. FIFO contents are retained.

FIFO (4 entries, circular, 2-bit read and write pointers, 3-bit count):
- Push with count < 4: store at the write pointer, write pointer +1 (wraps 3→0), count +1.
- Push with count = 4 and no pop: byte dropped, `overrun` set, pointers unchanged.
- Pop with count = 0: ignored.
- Push and pop in the same cycle:
  - count 1 to 3: both occur and count is unchanged.
  - count 4: the pop frees the slot and the push is accepted, with no overrun.
  - count 0: only the push takes effect.
- `rx_data` is the storage entry at the read pointer. It is undefined-free: storage resets to 0.

Error flags:
- `err_clr` clears both flags.
- If a new error occurs in the same cycle as `err_clr`, the set wins.

Reset values:
- `rx_data` = 0x00, `rx_valid` = 0, `rx_count` = 0, `frame_err` = 0, `overrun` = 0.
- State IDLE, pointers 0, divider 0, synchroniser 1.
- Reset mid-frame discards the partial byte and FIFO contents.

## Timing
- `rxd` to `rxs` latency: 2 cycles.
- Start detection occurs on the edge where `rxs` is first sampled 0.
- Stop decision occurs at tick 154 after detection (9 × 16 + 10), i.e. 154 × BAUD_DIV cycles after detection.
- `rx_valid` / `rx_count` update on that same edge and are visible the following cycle.
- `pop` takes effect on the clock edge where it is sampled high. The next entry appears on `rx_data` the following cycle.
- `frame_err` and `overrun` update on the edge of the causing decision.
- Maximum sustained rate is one byte per 10 bit-times, with a tolerance of ±3% baud mismatch.

## Test plan
All scenarios use BAUD_DIV = 4 (1 bit = 64 cycles) and `rx_en` = 1.
1. **Single byte:** send 0xA5 with a good stop bit, then pop once. Required: `rx_valid` rises 616 cycles after detection with `rx_data` = 0xA5 and `rx_count` = 1. After the pop: `rx_count` = 0, `rx_valid` = 0, no flags.
2. **Start glitch:** drive `rxd` low for 24 cycles, then high. Required: no push, `rx_count` = 0, FSM back in IDLE. A following byte 0x3C is received correctly.
3. **Framing error:** send 0x3C with stop = 0, hold `rxd` low 3 bit-times, then send 0x11. Required: `frame_err` = 1, 0x3C not stored, 0x11 stored (`rx_count` = 1). `err_clr` then returns `frame_err` to 0.
4. **Overrun:** send 0x01 through 0x05 without popping. Required: `rx_count` = 4, `overrun` = 1. Pops return 0x01, 0x02, 0x03, 0x04 in order, across pointer wrap.
5. **Full with pop:** with `rx_count` = 4, assert `pop` on the push edge of byte 0x66. Required: `rx_count` stays 4, `overrun` = 0, and 0x66 is the last entry popped.
6. **Reset mid-frame:** pulse `reset` during data bit 4 of 0x5A with 2 bytes already queued. Required: all outputs at reset values the next cycle. A subsequent 0x5A is received with `rx_count` = 1.
